// File: rtl/iq_stream_pkg.sv
// Shared types for the IQ stream sink: word type, TX sequencing states, zero word.
package iq_stream_pkg;
  localparam int IQ_DATA_W = 32;

  typedef logic [IQ_DATA_W-1:0] iq_word_t;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN
  } tx_state_t;

  localparam iq_word_t IQ_ZERO = '0;
endpackage

// File: rtl/iq_sync_fifo.sv
// Single-clock FIFO with registered occupancy; pop data is the head entry, valid while not empty.
// Push is ignored when full and pop is ignored when empty.
module iq_sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [W-1:0]               push_dat,
  input  logic                       pop,
  output logic [W-1:0]               pop_dat,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push, do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign pop_dat = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers are exactly AW bits wide, so increment wraps modulo DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat;
  end
endmodule

// File: rtl/iq_stream_sink_tx.sv
// Buffers host DMA IQ beats (byte-reversed) and hands one word per serializer request, 1-cycle latency.
// Sink ready depends only on FIFO occupancy; an empty FIFO in RUN yields a zero word and an underrun.
module iq_stream_sink_tx
  import iq_stream_pkg::*;
#(
  parameter int DATA_W    = IQ_DATA_W,
  parameter int DEPTH     = 8,
  parameter int PRIME_LVL = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        stream_tdata,
  input  logic                     stream_tvalid,
  output logic                     stream_tready,
  input  logic                     stream_tstart,
  input  logic                     stream_tlast,
  input  logic                     word_req_in,
  output logic [DATA_W-1:0]        iq_word_out,
  output logic                     word_valid_out,
  output logic                     underrun_out,
  output logic [15:0]              underrun_count,
  output logic                     framing_err,
  output logic [$clog2(DEPTH):0]   fifo_level
);
  localparam int NB = DATA_W / 8;
  localparam int LW = $clog2(DEPTH) + 1;

  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] iq_word_q, iq_word_d;
  logic              word_valid_q, word_valid_d;
  logic              underrun_q, underrun_d;
  logic [15:0]       underrun_cnt_q, underrun_cnt_d;
  logic              framing_q, framing_d;

  logic [DATA_W-1:0] swapped_dat, pop_dat;
  logic              full, empty, push, pop, underrun, in_run;

  always_comb begin
    swapped_dat = '0;
    for (int k = 0; k < NB; k++) begin
      swapped_dat[8*(NB-1-k) +: 8] = stream_tdata[8*k +: 8];
    end
  end

  assign stream_tready = !full;
  assign push          = stream_tvalid && !full;
  assign in_run        = (state_q == RUN);
  // Pop decision uses the pre-push occupancy: no same-cycle bypass.
  assign pop           = in_run && word_req_in && !empty;
  assign underrun      = in_run && word_req_in && empty;

  iq_sync_fifo #(
    .W     (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_dat (swapped_dat),
    .pop      (pop),
    .pop_dat  (pop_dat),
    .full     (full),
    .empty    (empty),
    .level    (fifo_level)
  );

  always_comb begin
    state_d        = state_q;
    iq_word_d      = iq_word_q;
    word_valid_d   = word_req_in;
    underrun_d     = underrun;
    underrun_cnt_d = underrun_cnt_q;
    framing_d      = framing_q | (push && !(stream_tstart && stream_tlast));

    unique case (state_q)
      IDLE:    if (push) state_d = PRIME;
      PRIME:   if (fifo_level >= LW'(PRIME_LVL)) state_d = RUN;
      RUN:     if (underrun) state_d = PRIME;
      default: state_d = IDLE;
    endcase

    if (word_req_in) iq_word_d = pop ? pop_dat : DATA_W'(IQ_ZERO);
    if (underrun && underrun_cnt_q != 16'hFFFF) underrun_cnt_d = underrun_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      iq_word_q      <= '0;
      word_valid_q   <= 1'b0;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= '0;
      framing_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      iq_word_q      <= iq_word_d;
      word_valid_q   <= word_valid_d;
      underrun_q     <= underrun_d;
      underrun_cnt_q <= underrun_cnt_d;
      framing_q      <= framing_d;
    end
  end

  assign iq_word_out    = iq_word_q;
  assign word_valid_out = word_valid_q;
  assign underrun_out   = underrun_q;
  assign underrun_count = underrun_cnt_q;
  assign framing_err    = framing_q;
endmodule

// File: tb/tb_iq_stream_sink_tx.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based reference model.
module tb_iq_stream_sink_tx;
  localparam int DATA_W    = 32;
  localparam int DEPTH     = 8;
  localparam int PRIME_LVL = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [DATA_W-1:0] stream_tdata = '0;
  logic              stream_tvalid = 1'b0;
  logic              stream_tready;
  logic              stream_tstart = 1'b0;
  logic              stream_tlast = 1'b0;
  logic              word_req_in = 1'b0;
  logic [DATA_W-1:0] iq_word_out;
  logic              word_valid_out;
  logic              underrun_out;
  logic [15:0]       underrun_count;
  logic              framing_err;
  logic [3:0]        fifo_level;

  iq_stream_sink_tx #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .PRIME_LVL (PRIME_LVL)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stream_tdata   (stream_tdata),
    .stream_tvalid  (stream_tvalid),
    .stream_tready  (stream_tready),
    .stream_tstart  (stream_tstart),
    .stream_tlast   (stream_tlast),
    .word_req_in    (word_req_in),
    .iq_word_out    (iq_word_out),
    .word_valid_out (word_valid_out),
    .underrun_out   (underrun_out),
    .underrun_count (underrun_count),
    .framing_err    (framing_err),
    .fifo_level     (fifo_level)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: the FIFO is a queue, the sequencing phase is 0=idle, 1=priming, 2=running.
  logic [31:0] m_q[$];
  int          m_phase = 0;
  logic [31:0] m_word = '0;
  bit          m_vld = 0, m_unr = 0, m_frm = 0;
  int          m_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] bswap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_phase = 0; m_word = '0; m_vld = 0; m_unr = 0; m_frm = 0; m_cnt = 0;
  endtask

  task automatic model_edge(input bit v, input logic [31:0] d, input bit s, input bit l, input bit r);
    int sz;
    bit acc;
    sz  = m_q.size();
    acc = v && (sz < DEPTH);
    m_vld = r;
    m_unr = 0;
    if (r) begin
      if (m_phase == 2 && sz > 0) m_word = m_q.pop_front();
      else m_word = '0;
      if (m_phase == 2 && sz == 0) begin
        m_unr = 1;
        if (m_cnt < 65535) m_cnt++;
      end
    end
    case (m_phase)
      0: if (acc) m_phase = 1;
      1: if (sz >= PRIME_LVL) m_phase = 2;
      default: if (m_unr) m_phase = 1;
    endcase
    if (acc) m_q.push_back(bswap(d));
    if (acc && !(s && l)) m_frm = 1;
  endtask

  task automatic check_outputs();
    chk("fifo_level", fifo_level, m_q.size());
    chk("word_valid", word_valid_out, m_vld);
    chk("iq_word", iq_word_out, m_word);
    chk("underrun_out", underrun_out, m_unr);
    chk("underrun_count", underrun_count, m_cnt);
    chk("framing_err", framing_err, m_frm);
  endtask

  task automatic cycle(input bit v, input logic [31:0] d, input bit s, input bit l, input bit r);
    @(negedge clk);
    stream_tvalid = v; stream_tdata = d; stream_tstart = s; stream_tlast = l; word_req_in = r;
    #1;
    chk("tready", stream_tready, (m_q.size() < DEPTH));
    model_edge(v, d, s, l, r);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle_cycle();
    cycle(0, '0, 0, 0, 0);
  endtask

  task automatic push_word(input logic [31:0] d);
    cycle(1, d, 1, 1, 0);
  endtask

  task automatic req_word();
    cycle(0, '0, 0, 0, 1);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_tready", stream_tready, 1);
    check_outputs();
    reset = 1'b0;

    // Basic path
    push_word(32'h11223344);
    push_word(32'h55667788);
    idle_cycle();
    req_word();
    chk("basic_w0", iq_word_out, 32'h44332211);
    req_word();
    chk("basic_w1", iq_word_out, 32'h88776655);

    // Underrun in RUN, then a request while priming
    req_word();
    chk("unr_pulse", underrun_out, 1);
    chk("unr_cnt1", underrun_count, 1);
    req_word();
    chk("unr_again_cnt", underrun_count, 1);
    chk("unr_again_word", iq_word_out, 0);

    // Framing error on a beat without SOP
    cycle(1, 32'hA1B2C3D4, 0, 1, 0);
    push_word(32'h01020304);
    idle_cycle();
    req_word();
    chk("frm_word", iq_word_out, 32'hD4C3B2A1);
    chk("frm_flag", framing_err, 1);
    req_word();

    // Fill to level 3, then simultaneous push and pop
    for (int i = 0; i < 3; i++) push_word($urandom);
    idle_cycle();
    cycle(1, $urandom, 1, 1, 1);
    chk("pushpop_lvl", fifo_level, 3);
    while (m_q.size() > 0) req_word();

    // Full FIFO with source holding the 9th word
    for (int i = 0; i < 8; i++) push_word(32'h100 + i);
    chk("full_lvl", fifo_level, 8);
    chk("full_tready", stream_tready, 0);
    cycle(1, 32'hDEADBEEF, 1, 1, 0);
    cycle(1, 32'hDEADBEEF, 1, 1, 1);
    chk("full_tready_after_pop", stream_tready, 1);
    cycle(1, 32'hDEADBEEF, 1, 1, 0);
    chk("full_9th_lvl", fifo_level, 8);
    while (m_q.size() > 0) req_word();

    // Reset mid-stream at level 5
    while (m_q.size() < 5) push_word($urandom);
    chk("pre_rst_lvl", fifo_level, 5);
    @(negedge clk);
    stream_tvalid = 0; word_req_in = 0;
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("mid_rst_tready", stream_tready, 1);
    check_outputs();
    @(negedge clk);
    reset = 1'b0;
    req_word();
    chk("post_rst_word", iq_word_out, 0);
    chk("post_rst_unr", underrun_out, 0);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      bit v, s, l, r;
      v = ($urandom_range(0, 99) < 55);
      s = ($urandom_range(0, 99) < 95);
      l = ($urandom_range(0, 99) < 95);
      r = ($urandom_range(0, 99) < ((i % 300 < 150) ? 35 : 65));
      cycle(v, $urandom, s, l, r);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
